// File: rtl/store_narrow_buf.sv
// Store-side narrowing write buffer: byte/half/word lane replication, byte enables, DEPTH-entry FIFO to DM.
// Optional ALIGN_EXC_EN: drop misaligned/reserved stores and pulse align_err instead of queueing them.
module store_narrow_buf #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic [CW-1:0] count,
    output logic          align_err
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   r_addr_mem  [DEPTH];
    logic [31:0]   r_wdata_mem [DEPTH];
    logic [3:0]    r_be_mem    [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_align_err;

    logic [31:0] w_waddr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_misalign;
    logic        w_full;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // Narrow the register value and replicate it so the enabled lanes carry the data.
    always_comb begin
        w_waddr = {st_addr[31:2], 2'b00};
        w_wdata = st_data;
        w_be    = 4'b1111;
        case (st_size)
            2'b00: begin
                w_wdata = {4{st_data[7:0]}};
                w_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{st_data[15:0]}};
                w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = st_data;
                w_be    = 4'b1111;
            end
        endcase
    end

`ifdef ALIGN_EXC_EN
    assign w_misalign = ((st_size == 2'b01) && st_addr[0])
                     || ((st_size == 2'b10) && (st_addr[1:0] != 2'b00))
                     || (st_size == 2'b11);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_full    = (r_count == CW'(DEPTH));
    assign st_ready  = reset && !w_full;
    assign mem_valid = (r_count != '0);
    assign w_accept  = st_valid && st_ready;
    assign w_push    = w_accept && !w_misalign;
    assign w_pop     = mem_valid && mem_ready;

    // Storage is not reset: the pointers and count alone decide what is live.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_addr_mem[gi]  <= w_waddr;
                    r_wdata_mem[gi] <= w_wdata;
                    r_be_mem[gi]    <= w_be;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_align_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_align_err <= w_accept && w_misalign;
        end
    end

    assign mem_addr  = mem_valid ? r_addr_mem[r_rd_ptr]  : 32'd0;
    assign mem_wdata = mem_valid ? r_wdata_mem[r_rd_ptr] : 32'd0;
    assign mem_be    = mem_valid ? r_be_mem[r_rd_ptr]    : 4'd0;
    assign count     = r_count;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_store_narrow_buf.sv
// Directed bench for store_narrow_buf: narrowing, FIFO order/wrap, full handling, reset flush.
module tb_store_narrow_buf;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;
    logic        align_err;

    int n_total = 0;
    int n_bad   = 0;

    store_narrow_buf #(.DEPTH(4), .CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus and sample 1ns after the rising edge.
    task automatic step(input logic rst_n, input logic sv, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic mr);
        reset     = rst_n;
        st_valid  = sv;
        st_addr   = a;
        st_data   = d;
        st_size   = sz;
        mem_ready = mr;
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b sv=%0b a=0x%08h d=0x%08h sz=%0d mr=%0b -> cnt=%0d mv=%0b ma=0x%08h wd=0x%08h be=%04b",
                 $time, rst_n, sv, a, d, sz, mr, count, mem_valid, mem_addr, mem_wdata, mem_be);
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        check({tag, "_valid"}, 32'(mem_valid), 32'd1);
        check({tag, "_addr"}, mem_addr, a);
        check({tag, "_wdata"}, mem_wdata, d);
        check({tag, "_be"}, 32'(mem_be), 32'(be));
    endtask

    initial begin
        #2;
        // Reset
        step(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_mvalid", 32'(mem_valid), 32'd0);
        check("rst_stready", 32'(st_ready), 32'd0);
        check("rst_aerr", 32'(align_err), 32'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        check("rel_stready", 32'(st_ready), 32'd1);

        // 1: byte store at lane 3
        step(1'b1, 1'b1, 32'h0000_1003, 32'h1234_56AB, 2'b00, 1'b1);
        check_head("sb", 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        check("sb_pop_count", 32'(count), 32'd0);
        check("empty_addr", mem_addr, 32'd0);
        check("empty_be", 32'(mem_be), 32'd0);

        // 2: half then word, held while DM stalls
        step(1'b1, 1'b1, 32'h0000_2002, 32'hFFFF_8001, 2'b01, 1'b0);
        check_head("sh", 32'h0000_2000, 32'h8001_8001, 4'b1100);
        step(1'b1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 2'b10, 1'b0);
        check("sw_count", 32'(count), 32'd2);
        check_head("sh_hold", 32'h0000_2000, 32'h8001_8001, 4'b1100);
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        check_head("sw", 32'h0000_2004, 32'hCAFE_F00D, 4'b1111);
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        check("sw_pop_count", 32'(count), 32'd0);

        // 3: fill while stalled
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10, 1'b0);
            check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
        end
        check("full_stready", 32'(st_ready), 32'd0);
        step(1'b1, 1'b1, 32'h110, 32'hA4, 2'b10, 1'b0);
        check("full_block_count", 32'(count), 32'd4);
        check_head("full_head", 32'h100, 32'hA0, 4'b1111);

        // 4: full + push + pop -> pop only, then push lands
        step(1'b1, 1'b1, 32'h110, 32'hA4, 2'b10, 1'b1);
        check("full_pp_count", 32'(count), 32'd3);
        check_head("full_pp_head", 32'h104, 32'hA1, 4'b1111);
        step(1'b1, 1'b1, 32'h110, 32'hA4, 2'b10, 1'b0);
        check("refill_count", 32'(count), 32'd4);
        for (int i = 1; i < 5; i++) begin
            check_head($sformatf("drain%0d", i), 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111);
            step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_mvalid", 32'(mem_valid), 32'd0);

        // 5: misaligned half
        step(1'b1, 1'b1, 32'h0000_3001, 32'h0000_1234, 2'b01, 1'b0);
`ifdef ALIGN_EXC_EN
        check("mis_count", 32'(count), 32'd0);
        check("mis_aerr", 32'(align_err), 32'd1);
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        check("mis_aerr_clr", 32'(align_err), 32'd0);
`else
        check("mis_count", 32'(count), 32'd1);
        check("mis_aerr", 32'(align_err), 32'd0);
        check_head("mis_sh", 32'h0000_3000, 32'h1234_1234, 4'b0011);
`endif
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1);
        check("mis_drain_count", 32'(count), 32'd0);

        // Push + pop at count==1 keeps valid and order
        step(1'b1, 1'b1, 32'h0000_4000, 32'h0000_0001, 2'b10, 1'b0);
        step(1'b1, 1'b1, 32'h0000_4002, 32'h0000_0077, 2'b00, 1'b1);
        check("pp1_count", 32'(count), 32'd1);
        check_head("pp1", 32'h0000_4000, 32'h7777_7777, 4'b0100);

        // 6: reset flushes a partly full buffer
        step(1'b1, 1'b1, 32'h0000_5000, 32'h0000_0005, 2'b10, 1'b0);
        step(1'b1, 1'b1, 32'h0000_5004, 32'h0000_0006, 2'b10, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        step(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_mvalid", 32'(mem_valid), 32'd0);
        check("flush_addr", mem_addr, 32'd0);
        check("flush_wdata", mem_wdata, 32'd0);
        check("flush_be", 32'(mem_be), 32'd0);
        check("flush_stready", 32'(st_ready), 32'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        check("post_rst_stready", 32'(st_ready), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
